// File: rtl/pixel_write_queue_pkg.sv
// Shared framebuffer geometry and the write record that travels through the queue.
package fb_pkg;
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_ADDR_W = 19;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef struct packed {
        fb_addr_t addr;
        logic     color;
    } fb_write_t;
endpackage

// File: rtl/pixel_write_queue_if.sv
// Pixel stream in from the line animator and framebuffer RAM write port out.
interface pixel_write_queue_if #(
    parameter int ADDR_W = fb_pkg::FB_ADDR_W
);
    logic              in_valid;
    logic [10:0]       in_x;
    logic [10:0]       in_y;
    logic              in_color;
    logic              fb_ready;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_data;

    modport master (
        output in_valid, in_x, in_y, in_color, fb_ready,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  in_valid, in_x, in_y, in_color, fb_ready,
        output fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/pixel_write_queue_fifo.sv
// Synchronous FIFO with show-ahead head; a push into a full FIFO lands only when a pop frees the slot.
module sync_fifo
    import fb_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = fb_write_t,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_i,
    input  logic           pop_i,
    input  T               din_i,
    output T               dout_o,
    output logic           empty_o,
    output logic           full_o,
    output logic [PTR_W:0] count_o
);
    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/pixel_write_queue.sv
// Clips pixels, converts to linear addresses and queues them for the framebuffer write port.
// Build option PIXEL_DEDUP_EN drops requests identical to the last in-range pixel.
module pixel_write_queue
    import fb_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    pixel_write_queue_if.slave  bus,
    output logic                full_o,
    output logic                busy_o,
    output logic [15:0]         overflow_count_o
);
    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [10:0] X_LIM = 11'(WIDTH);
    localparam logic [10:0] Y_LIM = 11'(HEIGHT);

    logic              in_range, dup, accept;
    logic [ADDR_W-1:0] pix_addr;
    logic              stage_valid_q, stage_valid_d;
    fb_write_t         stage_q, stage_d;
    fb_write_t         head, last_out_q;
    logic              empty, fifo_full, pop;
    logic [PTR_W:0]    count;
    logic [15:0]       ovf_q, ovf_d;

    assign in_range = (bus.in_x < X_LIM) && (bus.in_y < Y_LIM);
    assign pix_addr = ADDR_W'(bus.in_y) * ADDR_W'(WIDTH) + ADDR_W'(bus.in_x);

`ifdef PIXEL_DEDUP_EN
    logic        last_valid_q, last_valid_d;
    logic [22:0] last_q, last_d;

    assign dup = last_valid_q && (last_q == {bus.in_x, bus.in_y, bus.in_color});

    always_comb begin
        last_valid_d = last_valid_q;
        last_d       = last_q;
        if (bus.in_valid && in_range && !dup) begin
            last_valid_d = 1'b1;
            last_d       = {bus.in_x, bus.in_y, bus.in_color};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_valid_q <= 1'b0;
            last_q       <= '0;
        end else begin
            last_valid_q <= last_valid_d;
            last_q       <= last_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign accept = bus.in_valid && in_range && !dup;

    always_comb begin
        stage_valid_d = accept;
        stage_d       = stage_q;
        if (accept) begin
            stage_d.addr  = fb_addr_t'(pix_addr);
            stage_d.color = bus.in_color;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fb_write_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stage_valid_q),
        .pop_i   (pop),
        .din_i   (stage_q),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (fifo_full),
        .count_o (count)
    );

    assign pop = !empty && bus.fb_ready;

    // The stage never stalls: a full FIFO with no pop this cycle loses the staged write.
    always_comb begin
        ovf_d = ovf_q;
        if (stage_valid_q && fifo_full && !pop && ovf_q != 16'hFFFF)
            ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            ovf_q         <= '0;
            last_out_q    <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            ovf_q         <= ovf_d;
            if (pop) last_out_q <= head;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    // When drained, the port keeps showing the most recently written entry.
    assign bus.fb_we     = !empty;
    assign bus.fb_addr   = empty ? last_out_q.addr  : head.addr;
    assign bus.fb_data   = empty ? last_out_q.color : head.color;
    assign full_o           = fifo_full;
    assign busy_o           = stage_valid_q || !empty;
    assign overflow_count_o = ovf_q;
endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: table of single-pixel vectors plus multi-cycle sequences.
module tb_pixel_write_queue;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        full, busy;
    logic [15:0] ovf;

    always #5 clk = ~clk;

    pixel_write_queue_if bus ();

    pixel_write_queue dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .full_o           (full),
        .busy_o           (busy),
        .overflow_count_o (ovf)
    );

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        color;
        logic        hit;
        int          addr;
    } vec_t;

    typedef struct {
        int   addr;
        logic data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    wr_t  exp_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic c);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_color = c;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Compares any write accepted at the coming edge against the scoreboard head.
    task automatic observe(input string tag);
        wr_t e;
        if (bus.fb_we && bus.fb_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected write: got addr %0d expected none", tag, bus.fb_addr);
            end else begin
                e = exp_q.pop_front();
                check({tag, " addr"}, 32'(bus.fb_addr), e.addr);
                check({tag, " data"}, 32'(bus.fb_data), 32'(e.data));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic        prev_data;
        int          n_exp;

        vecs[0] = '{11'd5,    11'd2,   1'b1, 1'b1, 1285};
        vecs[1] = '{11'd639,  11'd479, 1'b1, 1'b1, 307199};
        vecs[2] = '{11'd0,    11'd0,   1'b0, 1'b1, 0};
        vecs[3] = '{11'd640,  11'd0,   1'b1, 1'b0, 0};
        vecs[4] = '{11'd0,    11'd480, 1'b1, 1'b0, 0};
        vecs[5] = '{11'd2047, 11'd10,  1'b1, 1'b0, 0};
        vecs[6] = '{11'd639,  11'd0,   1'b0, 1'b1, 639};
        vecs[7] = '{11'd0,    11'd479, 1'b1, 1'b1, 306560};

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_color = 1'b0;
        bus.fb_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset fb_we",   32'(bus.fb_we),   0);
        check("reset fb_addr", 32'(bus.fb_addr), 0);
        check("reset fb_data", 32'(bus.fb_data), 0);
        check("reset full",    32'(full),        0);
        check("reset busy",    32'(busy),        0);
        check("reset ovf",     32'(ovf),         0);

        // Single pixels: two-cycle latency for in-range, nothing for clipped.
        foreach (vecs[i]) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].color);
            step();
            idle();
            check($sformatf("vec%0d early we", i), 32'(bus.fb_we), 0);
            step();
            check($sformatf("vec%0d we", i), 32'(bus.fb_we), 32'(vecs[i].hit));
            if (vecs[i].hit) begin
                check($sformatf("vec%0d addr", i), 32'(bus.fb_addr), vecs[i].addr);
                check($sformatf("vec%0d data", i), 32'(bus.fb_data), 32'(vecs[i].color));
            end
            step();
            check($sformatf("vec%0d we after", i), 32'(bus.fb_we), 0);
            check($sformatf("vec%0d busy after", i), 32'(busy), 0);
        end
        check("clip ovf", 32'(ovf), 0);

        // 20 pixels into a stalled 16-deep queue.
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(11'(10 + i), 11'd1, 1'(i));
            step();
        end
        idle();
        step();
        check("ovf full",  32'(full),      1);
        check("ovf count", 32'(ovf),       4);
        check("ovf we",    32'(bus.fb_we), 1);
        bus.fb_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d we", k),   32'(bus.fb_we),   1);
            check($sformatf("drain%0d addr", k), 32'(bus.fb_addr), 650 + k);
            check($sformatf("drain%0d data", k), 32'(bus.fb_data), k & 1);
            step();
        end
        check("drain we end",   32'(bus.fb_we),   0);
        check("drain busy end", 32'(busy),        0);
        check("drain full end", 32'(full),        0);
        check("drain hold addr", 32'(bus.fb_addr), 665);
        check("drain hold data", 32'(bus.fb_data), 1);

        // Six-pixel burst with fb_ready toggling every cycle.
        exp_q.delete();
        pops = 0;
        prev_stall = 1'b0;
        prev_addr = '0;
        prev_data = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c < 6) begin
                drive(11'(100 + c), 11'(7 + c), (c % 2) == 0);
                exp_q.push_back('{(7 + c) * 640 + 100 + c, (c % 2) == 0});
            end else begin
                idle();
            end
            bus.fb_ready = (c % 2) == 0;
            if (prev_stall) begin
                check($sformatf("stall%0d addr", c), 32'(bus.fb_addr), prev_addr);
                check($sformatf("stall%0d data", c), 32'(bus.fb_data), 32'(prev_data));
            end
            observe("toggle");
            prev_stall = bus.fb_we && !bus.fb_ready;
            prev_addr  = 32'(bus.fb_addr);
            prev_data  = bus.fb_data;
            step();
        end
        check("toggle writes", pops, 6);
        check("toggle left", exp_q.size(), 0);
        check("toggle ovf", 32'(ovf), 4);

        // Reset with five entries queued; the reset-cycle pixel must be ignored.
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(11'(200 + i), 11'd20, 1'b1);
            step();
        end
        idle();
        step();
        check("pre-reset we", 32'(bus.fb_we), 1);
        reset = 1'b1;
        drive(11'd300, 11'd30, 1'b1);
        step();
        reset = 1'b0;
        idle();
        check("mid reset we",   32'(bus.fb_we),   0);
        check("mid reset busy", 32'(busy),        0);
        check("mid reset ovf",  32'(ovf),         0);
        check("mid reset addr", 32'(bus.fb_addr), 0);
        bus.fb_ready = 1'b1;
        exp_q.delete();
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            observe("post reset");
            check($sformatf("post reset we%0d", c), 32'(bus.fb_we), 0);
            step();
        end

        // Endpoint repeated ten times, then the same spot in the other colour.
        exp_q.delete();
        pops = 0;
`ifdef PIXEL_DEDUP_EN
        exp_q.push_back('{1923, 1'b1});
        n_exp = 2;
`else
        for (int i = 0; i < 10; i++) exp_q.push_back('{1923, 1'b1});
        n_exp = 11;
`endif
        exp_q.push_back('{1923, 1'b0});
        for (int c = 0; c < 25; c++) begin
            if (c < 10)       drive(11'd3, 11'd3, 1'b1);
            else if (c == 10) drive(11'd3, 11'd3, 1'b0);
            else              idle();
            observe("dedup");
            step();
        end
        check("dedup writes", pops, n_exp);
        check("dedup left", exp_q.size(), 0);
        check("dedup ovf", 32'(ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_write_queue.md
Name: pixel_write_queue

Overview:
- Downstream consumer of the line animator's per-cycle pixel stream (x, y, pixel_color).
- Clips each pixel to the visible frame and converts it to a linear framebuffer address.
- Buffers accepted writes in a small FIFO and drains them to the framebuffer RAM write port, which may stall because the VGA scan-out read side shares the RAM.
- Upstream has no backpressure, so when the FIFO is full, writes are dropped and counted.

Parameters:
- WIDTH, 640, visible columns; valid x range is 0..WIDTH-1.
- HEIGHT, 480, visible rows; valid y range is 0..HEIGHT-1.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- DEPTH, 16, FIFO entries; must be a power of two and >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset (see Behaviour).
- in_valid  input  1  pixel write request this cycle.
- in_x  input  11  pixel column, unsigned.
- in_y  input  11  pixel row, unsigned.
- in_color  input  1  pixel value (0 = black, 1 = white).
- fb_ready  input  1  RAM accepts a write this cycle.
- fb_we  output  1  write request; equals FIFO non-empty.
- fb_addr  output  ADDR_W  write address = y*WIDTH + x.
- fb_data  output  1  write data.
- full  output  1  FIFO holds DEPTH entries.
- busy  output  1  stage register valid OR FIFO non-empty.
- overflow_count  output  16  saturating count of dropped in-range writes.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - Clears the stage register valid bit, FIFO pointers and occupancy, and overflow_count.
  - After reset: fb_we=0, fb_addr=0, fb_data=0, full=0, busy=0, overflow_count=0.
  - Reset mid-operation discards all queued writes with no partial drain. Inputs in the reset cycle are ignored.
- Stage 1 (input register), at each edge with in_valid=1:
  - If in_x < WIDTH and in_y < HEIGHT: latch addr = in_y*WIDTH + in_x (computed at ADDR_W bits, no truncation for in-range values) and in_color, and set stage valid.
  - Otherwise discard silently and do not count it. Large 11-bit values (e.g. 2047 from upstream subtraction wrap) land here.
- Stage 2 (FIFO push): while stage valid, push {addr, color} at the next edge.
- Pop: fb_we is asserted combinationally whenever the FIFO is non-empty, and fb_addr/fb_data present the head entry.
  - The head is popped at an edge where fb_we && fb_ready.
  - fb_addr and fb_data hold stable while fb_we=1 and fb_ready=0.
  - When the FIFO is empty, fb_addr and fb_data hold their last values.
- Latency: a pixel sampled at edge E with the FIFO empty drives fb_we=1 during the cycle after edge E+1 (two-cycle latency). Throughput is 1 pixel/cycle when fb_ready is held high.
- Full boundary:
  - If full and a pop occurs in the same cycle, the push succeeds and occupancy is unchanged.
  - If full with no pop, the stage entry is dropped and overflow_count increments, saturating at 16'hFFFF.
  - The stage register never stalls.
- Empty boundary: a pop is only possible when non-empty. Push and pop on an empty FIFO cannot coincide because the head is visible only after the push.
- Pointers: log2(DEPTH) bits wrap naturally, plus a separate occupancy counter of log2(DEPTH)+1 bits. full = (count == DEPTH).

Optional Feature:
- Macro PIXEL_DEDUP_EN.
- Defined:
  - Stage 1 keeps the last in-range pixel {x, y, color} with a last_valid flag; last_valid is cleared by reset.
  - An in-range request identical to that pixel is discarded, is not counted, and does not update the stored pixel.
  - This suppresses the line drawer repeating its endpoint while holding after finished.
- Not defined: every in-range request is queued, and no comparison registers exist.

Decomposition:
- Package fb_pkg holds:
  - constants FB_WIDTH=640, FB_HEIGHT=480, FB_ADDR_W=19;
  - typedef fb_addr_t (logic [FB_ADDR_W-1:0]);
  - typedef struct packed fb_write_t {fb_addr_t addr; logic color;}.
- One sub-module, sync_fifo:
  - parameterised by DEPTH and element type fb_write_t;
  - ports push, pop, din, dout, empty, full, count.
- Clipping, address multiply, dedup and overflow counting stay in pixel_write_queue.

Test Plan:
- Reset, then in_valid=1 for one cycle with (x=5, y=2, color=1) and fb_ready=1 -> fb_we=1 exactly two cycles later with fb_addr=1285 and fb_data=1, for one cycle; busy then drops.
- Boundary pixels (639,479) and (0,0) -> addresses 307199 and 0. Pixels (640,0), (0,480) and (2047,10) -> never reach fb_we, overflow_count stays 0.
- fb_ready=0 while 20 consecutive in-range pixels arrive, DEPTH=16:
  - full=1 after 16 pushes, overflow_count=4;
  - then fb_ready=1 drains exactly the first 16 in order, and fb_we deasserts.
- fb_ready toggled 1,0,1,0 during a 6-pixel burst -> output order matches input order, fb_addr/fb_data stable whenever fb_we=1 and fb_ready=0, nothing dropped.
- Reset asserted with 5 entries queued -> next cycle fb_we=0, busy=0, overflow_count=0, and none of the queued writes appear afterward.
- With PIXEL_DEDUP_EN: (3,3,1) repeated 10 times, then (3,3,0) -> exactly two writes, addr 1923 data 1 followed by addr 1923 data 0. Without the macro -> 11 writes.
